mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single-port unified memory between the instruction-fetch path and the load/store path of the datapath. Accepts one request at a time, drives the memory port, counts the fixed memory latency and returns completion and read data to the owning requester. Sits between the datapath and `Mem` and replaces the direct fetch/data connections. It stalls the losing requester by withholding `*_ready`.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: byte-address width.
- `MEM_LAT`, 1: cycles from `mem_en` to valid `mem_rdata`; legal range 1..7.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: asynchronous, active-high.
- `if_req`  in  1: fetch request.
- `if_addr`  in  ADDR_W: fetch address.
- `if_ready`  out  1: fetch request accepted this cycle.
- `if_done`  out  1: fetch data valid (1-cycle pulse).
- `if_rdata`  out  DATA_W: fetch data.
- `dm_req`  in  1: data request.
- `dm_we`  in  1: 1 = store, 0 = load.
- `dm_addr`  in  ADDR_W: data address.
- `dm_wdata`  in  DATA_W: store data.
- `dm_ready`  out  1: data request accepted this cycle.
- `dm_done`  out  1: load data valid or store complete (1-cycle pulse).
- `dm_rdata`  out  DATA_W: load data.
- `mem_en`, `mem_we`  out  1: memory enable and write strobe.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data, valid MEM_LAT cycles after `mem_en`.

## Operation
- FSM states are IDLE and BUSY. Registered state: `owner` (IF/DM), `is_write`, latency counter `cnt` (3 bits), `last_grant`.
- **Accept window:** the arbiter accepts a request when the FSM is in IDLE, or when it is in BUSY with `cnt == MEM_LAT-1` (the done cycle). Back-to-back access is therefore supported.
- **Arbitration (combinational), with no conflict:** the only requester wins.
- **Arbitration on conflict:** DM wins, unless `last_grant == DM`, in which case IF wins. Conflicts therefore alternate, and neither port waits more than one access.
- **Grant cycle:**
  - The winner's `*_ready` is 1.
  - `mem_en = 1`.
  - `mem_addr`, `mem_we` and `mem_wdata` pass through combinationally from the winner; `mem_we = 0` for IF.
  - The arbiter latches `owner` and `is_write`, sets `last_grant`, clears `cnt` to 0 and enters BUSY.
- **BUSY:** `cnt` increments each cycle.
  - When `cnt == MEM_LAT-1`, the owner's `*_done` pulses for one cycle.
  - In that same cycle, `*_rdata = mem_rdata`; `dm_rdata` is don't-care for stores.
  - Next state is BUSY if a new grant occurs in that cycle, otherwise IDLE.
- `*_rdata` is registered-free: it is driven combinationally from `mem_rdata` and is qualified only by `*_done`.
- Requesters must hold `req`, `addr` and data stable until `ready`. The arbiter does not buffer un-accepted requests.
- A requester may deassert `req` before `ready` without side effects.
- When no grant occurs, `mem_en = 0` and `mem_we = 0`.

## Timing
- **Reset values:**
  - FSM state IDLE, `cnt = 0`, `last_grant = IF`.
  - All `*_ready`, `*_done`, `mem_en` and `mem_we` are 0 while `reset` is high.
  - Data outputs are don't-care during reset.
- **Latency:** `*_done` occurs MEM_LAT cycles after the `*_ready` cycle.
- **Throughput:** one access per MEM_LAT cycles at full occupancy.
- **Reset mid-access:** the outstanding access is abandoned and no `*_done` is produced. `mem_we` drops immediately, because reset is asynchronous.
- `if_ready` and `dm_ready` are never both 1 in the same cycle.
- `*_done` is never asserted for the non-owner.
- A request that arrives while the FSM is in BUSY and before the done cycle waits. It sees `ready` no earlier than the done cycle.

## Structure
- **Shared package:** owner encoding (`OWN_IF = 0`, `OWN_DM = 1`), FSM state encoding, and the maximum latency constant `MEM_LAT_MAX = 7`.
- **Natural sub-module:** `rr_pick2`, a combinational 2-way pick with a last-grant pointer. The FSM, counter and muxing stay in the top.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- **IF only, MEM_LAT=1:** hold `if_req` with addresses 0, 4, 8 → `if_ready` every cycle; `if_done` one cycle after each `ready`; `if_rdata` equals memory contents.
- **Conflict:** `if_req` and `dm_req` (load, addr 0x2000) both held from the first cycle after reset → grant order DM, IF, DM, IF; `if_ready` and `dm_ready` never overlap.
- **Store then load, MEM_LAT=3:** store 0x0000_0019 to 0x100, then load 0x100 → `dm_done` 3 cycles after each `ready`; load returns 0x19; `mem_we` high only in the store grant cycle.
- **Back-to-back, MEM_LAT=2:** continuous DM loads → `dm_ready` pulses every 2 cycles; the new `mem_en` coincides with the prior `dm_done`.
- **Reset mid-access:** assert `reset` one cycle after a `dm_ready` with MEM_LAT=3 → no `dm_done`; all strobes 0; the first post-reset conflict grants DM.
- **Request withdrawn:** raise `if_req` during BUSY, drop it before the done cycle → no IF grant, `mem_en` stays 0 after the done cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_LAT_MAX = 7;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way combinational pick; on conflict the side not granted last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_req_if,
  input  logic   i_req_dm,
  input  owner_e i_last,
  output logic   o_gnt_if,
  output logic   o_gnt_dm
);

  // DM is preferred on conflict unless it took the previous grant.
  assign o_gnt_dm = i_req_dm & (~i_req_if | (i_last != OWN_DM));
  assign o_gnt_if = i_req_if & (~i_req_dm | (i_last == OWN_DM));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// One access in flight; a new grant may overlap the done cycle of the previous one.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_e     r_state, w_state_nxt;
  owner_e     r_owner, w_owner_nxt;
  owner_e     r_last, w_last_nxt;
  logic       r_is_write, w_is_write_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       w_done, w_accept, w_gnt_if, w_gnt_dm, w_gnt;

  assign w_done   = (r_state == ST_BUSY) && (r_cnt == LAT_LAST);
  // Reset is asynchronous, so it gates the accept window directly to hold every strobe low.
  assign w_accept = ~reset & ((r_state == ST_IDLE) | w_done);

  rr_pick2 u_pick (
    .i_req_if (if_req & w_accept),
    .i_req_dm (dm_req & w_accept),
    .i_last   (r_last),
    .o_gnt_if (w_gnt_if),
    .o_gnt_dm (w_gnt_dm)
  );

  assign w_gnt = w_gnt_if | w_gnt_dm;

  assign if_ready  = w_gnt_if;
  assign dm_ready  = w_gnt_dm;
  assign mem_en    = w_gnt;
  assign mem_we    = w_gnt_dm & dm_we;
  assign mem_addr  = w_gnt_dm ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;

  assign if_done  = w_done & (r_owner == OWN_IF);
  assign dm_done  = w_done & (r_owner == OWN_DM);
  assign if_rdata = mem_rdata;
  // Store completions carry no data; zero it rather than expose a stale read.
  assign dm_rdata = r_is_write ? '0 : mem_rdata;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_nxt    = r_owner;
    w_is_write_nxt = r_is_write;
    w_last_nxt     = r_last;
    case (r_state)
      ST_IDLE: w_cnt_nxt = r_cnt;
      ST_BUSY: begin
        w_cnt_nxt = r_cnt + 3'd1;
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_gnt) begin
      w_state_nxt    = ST_BUSY;
      w_cnt_nxt      = 3'd0;
      w_owner_nxt    = w_gnt_dm ? OWN_DM : OWN_IF;
      w_is_write_nxt = w_gnt_dm & dm_we;
      w_last_nxt     = w_gnt_dm ? OWN_DM : OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_owner    <= OWN_IF;
      r_is_write <= 1'b0;
      r_last     <= OWN_IF;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_is_write <= w_is_write_nxt;
      r_last     <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: three arbiters at MEM_LAT 1..3, each with its own latency memory model.
// Directed tables, hand sequences and random traffic against a cycle-level reference.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req [NL], if_ready [NL], if_done [NL];
  logic [31:0] if_addr [NL], if_rdata [NL];
  logic        dm_req [NL], dm_we [NL], dm_ready [NL], dm_done [NL];
  logic [31:0] dm_addr [NL], dm_wdata [NL], dm_rdata [NL];
  logic        mem_en [NL], mem_we [NL];
  logic [31:0] mem_addr [NL], mem_wdata [NL], mem_rdata [NL];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd3);
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_ln
    localparam int LAT = g + 1;
    logic [31:0] hw_mem [logic [31:0]];
    logic [31:0] pipe [LAT];

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]),
      .if_done(if_done[g]), .if_rdata(if_rdata[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_ready(dm_ready[g]), .dm_done(dm_done[g]), .dm_rdata(dm_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );

    assign mem_rdata[g] = pipe[LAT-1];

    always @(posedge clk) begin
      if (mem_en[g]) begin
        pipe[0] <= hw_mem.exists(mem_addr[g]) ? hw_mem[mem_addr[g]] : memval(mem_addr[g]);
        if (mem_we[g]) hw_mem[mem_addr[g]] = mem_wdata[g];
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  task automatic chk1(input int ln, input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %b want %b at %0t", ln, nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input int ln, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %h want %h at %0t", ln, nm, act, exp, $time);
    end
  endtask

  // Reference model: an access granted at cycle c completes at cycle c+LAT.
  int          cyc = 0;
  logic        m_busy [NL];
  owner_e      m_own [NL], m_last [NL];
  int          m_due [NL];
  logic        m_st [NL];
  logic [31:0] m_rd [NL];
  logic [31:0] shadow [logic [33:0]];

  task automatic model_step(input int l);
    logic dn, gi, gd;
    logic [31:0] a;
    logic [33:0] key;
    if (reset) begin
      m_busy[l] = 1'b0;
      m_last[l] = OWN_IF;
      chk1(l, "rst if_ready", if_ready[l], 1'b0);
      chk1(l, "rst dm_ready", dm_ready[l], 1'b0);
      chk1(l, "rst if_done", if_done[l], 1'b0);
      chk1(l, "rst dm_done", dm_done[l], 1'b0);
      chk1(l, "rst mem_en", mem_en[l], 1'b0);
      chk1(l, "rst mem_we", mem_we[l], 1'b0);
    end else begin
      dn = m_busy[l] && (cyc == m_due[l]);
      gi = 1'b0;
      gd = 1'b0;
      if (!m_busy[l] || dn) begin
        if (if_req[l] && dm_req[l]) begin
          if (m_last[l] == OWN_DM) gi = 1'b1; else gd = 1'b1;
        end else begin
          gi = if_req[l];
          gd = dm_req[l];
        end
      end
      chk1(l, "m if_ready", if_ready[l], gi);
      chk1(l, "m dm_ready", dm_ready[l], gd);
      chk1(l, "m if_done", if_done[l], dn && (m_own[l] == OWN_IF));
      chk1(l, "m dm_done", dm_done[l], dn && (m_own[l] == OWN_DM));
      chk1(l, "m mem_en", mem_en[l], gi || gd);
      chk1(l, "m mem_we", mem_we[l], gd && dm_we[l]);
      a = gd ? dm_addr[l] : if_addr[l];
      if (gi || gd) chk32(l, "m mem_addr", mem_addr[l], a);
      if (gd && dm_we[l]) chk32(l, "m mem_wdata", mem_wdata[l], dm_wdata[l]);
      if (dn && m_own[l] == OWN_IF) chk32(l, "m if_rdata", if_rdata[l], m_rd[l]);
      if (dn && m_own[l] == OWN_DM && !m_st[l]) chk32(l, "m dm_rdata", dm_rdata[l], m_rd[l]);
      if (dn) m_busy[l] = 1'b0;
      if (gi || gd) begin
        key       = {2'(l), a};
        m_busy[l] = 1'b1;
        m_due[l]  = cyc + l + 1;
        m_own[l]  = gd ? OWN_DM : OWN_IF;
        m_last[l] = m_own[l];
        m_st[l]   = gd && dm_we[l];
        m_rd[l]   = shadow.exists(key) ? shadow[key] : memval(a);
        if (m_st[l]) shadow[key] = dm_wdata[l];
      end
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    cyc++;
    for (int l = 0; l < NL; l++) model_step(l);
  endtask

  task automatic pdrive();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    for (int l = 0; l < NL; l++) begin
      if_req[l] = 1'b0; if_addr[l] = '0;
      dm_req[l] = 1'b0; dm_we[l] = 1'b0; dm_addr[l] = '0; dm_wdata[l] = '0;
    end
  endtask

  typedef struct {
    int ln;
    bit iq; bit [31:0] ia;
    bit dq; bit dw; bit [31:0] da; bit [31:0] dd;
    bit ifr; bit dmr; bit ifd; bit dmd; bit en; bit we;
    bit [31:0] ea; bit rc; bit [31:0] rd;
  } vec_t;
  vec_t vt [$];

  task automatic v(input int ln, input bit iq, input bit [31:0] ia, input bit dq, input bit dw,
                   input bit [31:0] da, input bit [31:0] dd, input bit ifr, input bit dmr,
                   input bit ifd, input bit dmd, input bit en, input bit we,
                   input bit [31:0] ea, input bit rc, input bit [31:0] rd);
    vec_t r;
    r.ln = ln; r.iq = iq; r.ia = ia; r.dq = dq; r.dw = dw; r.da = da; r.dd = dd;
    r.ifr = ifr; r.dmr = dmr; r.ifd = ifd; r.dmd = dmd; r.en = en; r.we = we;
    r.ea = ea; r.rc = rc; r.rd = rd;
    vt.push_back(r);
  endtask

  logic ai [NL], ad [NL];

  initial begin
    for (int l = 0; l < NL; l++) begin
      m_busy[l] = 1'b0; m_own[l] = OWN_IF; m_last[l] = OWN_IF;
      m_due[l] = 0; m_st[l] = 1'b0; m_rd[l] = '0;
    end
    // Conflict on lane 0 (LAT 1) straight out of reset: DM, IF, DM, IF.
    v(0, 1, 32'h40, 1, 0, 32'h2000, 0,  0, 1, 0, 0, 1, 0, 32'h2000, 0, 0);
    v(0, 1, 32'h40, 1, 0, 32'h2000, 0,  1, 0, 0, 1, 1, 0, 32'h40,   1, memval(32'h2000));
    v(0, 1, 32'h40, 1, 0, 32'h2000, 0,  0, 1, 1, 0, 1, 0, 32'h2000, 1, memval(32'h40));
    v(0, 1, 32'h40, 1, 0, 32'h2000, 0,  1, 0, 0, 1, 1, 0, 32'h40,   1, memval(32'h2000));
    v(0, 0, 0,      0, 0, 0,       0,  0, 0, 1, 0, 0, 0, 0,        1, memval(32'h40));
    v(0, 0, 0,      0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,        0, 0);
    // IF-only stream on lane 0: ready every cycle, done one cycle later.
    v(0, 1, 32'h0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    v(0, 1, 32'h4, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 32'h4, 1, memval(32'h0));
    v(0, 1, 32'h8, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 32'h8, 1, memval(32'h4));
    v(0, 0, 0,     0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,     1, memval(32'h8));
    v(0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,     0, 0);
    // Back-to-back loads on lane 1 (LAT 2): new grant lands on the previous done.
    v(1, 0, 0, 1, 0, 32'h200, 0,  0, 1, 0, 0, 1, 0, 32'h200, 0, 0);
    v(1, 0, 0, 1, 0, 32'h200, 0,  0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(1, 0, 0, 1, 0, 32'h200, 0,  0, 1, 0, 1, 1, 0, 32'h200, 1, memval(32'h200));
    v(1, 0, 0, 1, 0, 32'h200, 0,  0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(1, 0, 0, 1, 0, 32'h200, 0,  0, 1, 0, 1, 1, 0, 32'h200, 1, memval(32'h200));
    v(1, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(1, 0, 0, 0, 0, 0,       0,  0, 0, 0, 1, 0, 0, 0,       1, memval(32'h200));
    v(1, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,       0, 0);
    // Store then load on lane 2 (LAT 3).
    v(2, 0, 0, 1, 1, 32'h100, 32'h19,  0, 1, 0, 0, 1, 1, 32'h100, 0, 0);
    v(2, 0, 0, 1, 0, 32'h100, 0,       0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(2, 0, 0, 1, 0, 32'h100, 0,       0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(2, 0, 0, 1, 0, 32'h100, 0,       0, 1, 0, 1, 1, 0, 32'h100, 0, 0);
    v(2, 0, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(2, 0, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(2, 0, 0, 0, 0, 0,       0,       0, 0, 0, 1, 0, 0, 0,       1, 32'h19);
    v(2, 0, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0, 0, 0,       0, 0);
    // IF request withdrawn while lane 2 is busy: no grant after the done cycle.
    v(2, 0, 0,     1, 0, 32'h140, 0,  0, 1, 0, 0, 1, 0, 32'h140, 0, 0);
    v(2, 1, 32'h80, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(2, 0, 0,     0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,       0, 0);
    v(2, 0, 0,     0, 0, 0,       0,  0, 0, 0, 1, 0, 0, 0,       1, memval(32'h140));
    v(2, 0, 0,     0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,       0, 0);

    reset = 1'b1;
    clr_inputs();
    nedge();
    nedge();
    pdrive();
    reset = 1'b0;

    foreach (vt[i]) begin
      if (i != 0) pdrive();
      clr_inputs();
      if_req[vt[i].ln] = vt[i].iq; if_addr[vt[i].ln] = vt[i].ia;
      dm_req[vt[i].ln] = vt[i].dq; dm_we[vt[i].ln] = vt[i].dw;
      dm_addr[vt[i].ln] = vt[i].da; dm_wdata[vt[i].ln] = vt[i].dd;
      nedge();
      chk1(vt[i].ln, $sformatf("v%0d if_ready", i), if_ready[vt[i].ln], vt[i].ifr);
      chk1(vt[i].ln, $sformatf("v%0d dm_ready", i), dm_ready[vt[i].ln], vt[i].dmr);
      chk1(vt[i].ln, $sformatf("v%0d if_done", i), if_done[vt[i].ln], vt[i].ifd);
      chk1(vt[i].ln, $sformatf("v%0d dm_done", i), dm_done[vt[i].ln], vt[i].dmd);
      chk1(vt[i].ln, $sformatf("v%0d mem_en", i), mem_en[vt[i].ln], vt[i].en);
      chk1(vt[i].ln, $sformatf("v%0d mem_we", i), mem_we[vt[i].ln], vt[i].we);
      if (vt[i].en) chk32(vt[i].ln, $sformatf("v%0d mem_addr", i), mem_addr[vt[i].ln], vt[i].ea);
      if (vt[i].rc && vt[i].ifd) chk32(vt[i].ln, $sformatf("v%0d if_rdata", i), if_rdata[vt[i].ln], vt[i].rd);
      if (vt[i].rc && vt[i].dmd) chk32(vt[i].ln, $sformatf("v%0d dm_rdata", i), dm_rdata[vt[i].ln], vt[i].rd);
    end

    // Reset one cycle after a lane 2 load grant: access abandoned, no done.
    pdrive();
    clr_inputs();
    dm_req[2] = 1'b1; dm_addr[2] = 32'h300;
    nedge();
    chk1(2, "rm dm_ready", dm_ready[2], 1'b1);
    pdrive();
    dm_req[2] = 1'b0;
    reset = 1'b1;
    #1;
    chk1(2, "rm en", mem_en[2], 1'b0);
    chk1(2, "rm done", dm_done[2], 1'b0);
    nedge();
    pdrive();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      nedge();
      chk1(2, "rm no done", dm_done[2], 1'b0);
      pdrive();
    end
    // Reset asserted mid grant cycle of a store drops mem_we at once.
    dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 32'h304; dm_wdata[2] = 32'hDEAD_BEEF;
    #2;
    chk1(2, "async we before", mem_we[2], 1'b1);
    reset = 1'b1;
    #1;
    chk1(2, "async we after", mem_we[2], 1'b0);
    chk1(2, "async ready after", dm_ready[2], 1'b0);
    nedge();
    pdrive();
    reset = 1'b0;
    clr_inputs();
    if_req[2] = 1'b1; if_addr[2] = 32'h40;
    dm_req[2] = 1'b1; dm_addr[2] = 32'h2000;
    nedge();
    chk1(2, "post-rst dm_ready", dm_ready[2], 1'b1);
    chk1(2, "post-rst if_ready", if_ready[2], 1'b0);
    pdrive();
    clr_inputs();
    repeat (4) nedge();

    // Random traffic obeying hold-until-ready, with occasional withdrawals and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < NL; l++) begin
        ai[l] = if_ready[l];
        ad[l] = dm_ready[l];
      end
      pdrive();
      reset = (c % 700 == 350);
      for (int l = 0; l < NL; l++) begin
        if (!if_req[l] || ai[l]) begin
          if_req[l]  = ($urandom_range(0, 2) != 0);
          if_addr[l] = 32'($urandom_range(0, 255)) << 2;
        end else if ($urandom_range(0, 15) == 0) begin
          if_req[l] = 1'b0;
        end
        if (!dm_req[l] || ad[l]) begin
          dm_req[l]   = ($urandom_range(0, 2) != 0);
          dm_we[l]    = ($urandom_range(0, 2) == 0);
          dm_addr[l]  = 32'($urandom_range(0, 255)) << 2;
          dm_wdata[l] = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          dm_req[l] = 1'b0;
        end
      end
      nedge();
      for (int l = 0; l < NL; l++)
        chk1(l, "ready overlap", if_ready[l] & dm_ready[l], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
